// File: rtl/rf_capture_pkg.sv
// Shared definitions for the echo-capture block.
//   - capture state encoding
//   - default sample / address widths
//   - comparator synchronizer depth and the data delay derived from it
package rf_capture_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;

  // Two synchronizer flops plus one registered edge-detect stage.
  localparam int SYNC_DEPTH   = 2;
  localparam int DEF_DATA_DLY = SYNC_DEPTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

  function automatic logic is_busy(input cap_state_t s);
    return (s == ST_FILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/capture_dpram.sv
// Simple dual-port capture RAM: one write port, one read port with a
// registered output. Contents are not reset; only the output register is.
// Ports:
//   clk, reset            : clock, async active-high reset (output reg only)
//   i_wr_en/addr/data     : write port
//   i_rd_en/addr          : read request, data appears next cycle
//   o_rd_data             : registered read data, holds when i_rd_en is low
module capture_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/adc_echo_capture.sv
// Echo-waveform capture. Records ADC samples into a circular buffer and
// freezes a window of PRETRIG samples before the first comparator rising
// edge plus the remainder of the buffer after it.
// Ports:
//   clk, reset       : ADC output clock, async active-high reset
//   adc_data         : sample, valid every clock
//   comparator       : asynchronous comparator output
//   arm, abort       : start capture pulse / force idle level
//   timeout_cycles   : trigger wait limit, 0 = no limit
//   rd_en, rd_addr   : read strobe and logical offset (0 = oldest pre-trigger)
//   rd_data,rd_valid : read result, one cycle after rd_en
//   busy, done       : capture in progress / window frozen
//   timed_out        : last capture ended without a trigger
//   trig_pos         : physical address of the trigger sample
//
// state     | meaning
// IDLE      | no recording, waiting for arm
// FILL      | recording the first PRETRIG samples, edges ignored
// WAIT_TRIG | recording, waiting for comparator edge or timeout
// POST      | recording the samples after the trigger
// DONE      | buffer frozen, readable
module adc_echo_capture
  import rf_capture_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PRETRIG  = 64,
  parameter int DATA_DLY = DEF_DATA_DLY,
  parameter int TMO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              comparator,
  input  logic              arm,
  input  logic              abort,
  input  logic [TMO_W-1:0]  timeout_cycles,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [ADDR_W-1:0] trig_pos
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(DEPTH - PRETRIG - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

  cap_state_t r_state, w_state_next;

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_sync_dly;
  logic                  r_edge;
  logic                  w_sync;

  logic [DATA_W-1:0] r_pipe [DATA_DLY];
  logic [DATA_W-1:0] w_wr_data;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [TMO_W-1:0]  w_tmo_inc;
  logic              w_tmo_hit;
  logic [ADDR_W-1:0] r_trig_pos;
  logic              r_timed_out;
  logic              r_rd_valid;
  logic              w_busy;
  logic              w_done;
  logic              w_wr_en;
  logic              w_rd_fire;
  logic              w_arm_ok;
  logic [ADDR_W-1:0] w_rd_phys;

  // Comparator synchronizer, delayed copy and registered rising edge.
  // The edge register adds one cycle, which DATA_DLY compensates.
  assign w_sync = r_sync[SYNC_DEPTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_sync_dly <= 1'b0;
      r_edge     <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_DEPTH-2:0], comparator};
      r_sync_dly <= w_sync;
      r_edge     <= w_sync & ~r_sync_dly;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DATA_DLY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= adc_data;
      for (int i = 1; i < DATA_DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_wr_data = r_pipe[DATA_DLY-1];

  // Saturating WAIT_TRIG cycle count; w_tmo_inc is the count including
  // the current cycle, so the hit lands on exactly timeout_cycles cycles.
  assign w_tmo_inc = (r_tmo_cnt == '1) ? r_tmo_cnt : r_tmo_cnt + TMO_ONE;
  assign w_tmo_hit = (timeout_cycles != '0) && (w_tmo_inc == timeout_cycles);

  assign w_arm_ok  = arm && !abort;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (arm) w_state_next = ST_FILL;
        ST_FILL:      if (r_fill_cnt == PRE_LAST) w_state_next = ST_WAIT_TRIG;
        ST_WAIT_TRIG: begin
          if (r_edge)         w_state_next = ST_POST;
          else if (w_tmo_hit) w_state_next = ST_DONE;
        end
        ST_POST:      if (r_post_cnt == ADDR_ONE) w_state_next = ST_DONE;
        ST_DONE:      if (arm) w_state_next = ST_FILL;
        default:      w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    w_busy  = is_busy(r_state);
    w_done  = (r_state == ST_DONE);
    w_wr_en = w_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_post_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_trig_pos  <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_ONE;

      r_tmo_cnt <= (r_state == ST_WAIT_TRIG) ? w_tmo_inc : '0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_arm_ok) begin
            r_fill_cnt  <= '0;
            r_timed_out <= 1'b0;
          end
        end
        ST_FILL: r_fill_cnt <= r_fill_cnt + ADDR_ONE;
        ST_WAIT_TRIG: begin
          if (!abort) begin
            if (r_edge) begin
              r_trig_pos <= r_wr_ptr;
              r_post_cnt <= POST_INIT;
            end else if (w_tmo_hit) begin
              r_trig_pos  <= r_wr_ptr;
              r_timed_out <= 1'b1;
            end
          end
        end
        ST_POST: r_post_cnt <= r_post_cnt - ADDR_ONE;
        default: ;
      endcase

      if (abort) r_timed_out <= 1'b0;
    end
  end

  // Reads only fetch from the RAM while frozen, so rd_data holds otherwise.
  assign w_rd_fire = rd_en && (r_state == ST_DONE);
  assign w_rd_phys = r_trig_pos - PRE_OFS + rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_valid <= 1'b0;
    else       r_rd_valid <= w_rd_fire;
  end

  capture_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dpram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (w_rd_phys),
    .o_rd_data (rd_data)
  );

  assign rd_valid  = r_rd_valid;
  assign busy      = w_busy;
  assign done      = w_done;
  assign timed_out = r_timed_out;
  assign trig_pos  = r_trig_pos;

endmodule

// File: tb/tb_adc_echo_capture.sv
module tb_adc_echo_capture;

  localparam int PRE = 64;

  logic        clk;
  logic        reset;
  logic [7:0]  adc_data;
  logic        comparator;
  logic        arm;
  logic        abort;
  logic [15:0] timeout_cycles;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [9:0]  trig_pos;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       vld;
    logic       chk_data;
    logic [7:0] data;
    string      tag;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  adc_echo_capture dut (
    .clk            (clk),
    .reset          (reset),
    .adc_data       (adc_data),
    .comparator     (comparator),
    .arm            (arm),
    .abort          (abort),
    .timeout_cycles (timeout_cycles),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .busy           (busy),
    .done           (done),
    .timed_out      (timed_out),
    .trig_pos       (trig_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; the ADC ramp advances once per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    adc_data = adc_data + 8'd1;
  endtask

  task automatic rd(input string tag, input logic [9:0] ofs, input logic vld,
                    input logic chk_d, input logic [7:0] exp_d);
    rd_exp_t e;
    e.vld      = vld;
    e.chk_data = chk_d;
    e.data     = exp_d;
    e.tag      = tag;
    sb_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = ofs;
    tick();
    rd_en = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_vld"}, 32'(rd_valid), 32'(e.vld));
      if (e.chk_data) chk({e.tag, "_data"}, 32'(rd_data), 32'(e.data));
    end
  endtask

  task automatic arm_capture();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int max_n, input int arm_at, output int n);
    n = 0;
    while (done !== 1'b1 && n < max_n) begin
      if (n == arm_at) arm = 1'b1;
      tick();
      arm = 1'b0;
      n++;
      if (n == 6) comparator = 1'b0;
    end
  endtask

  initial begin
    logic [9:0] wp;
    logic [9:0] exp_trig;
    logic [9:0] off;
    logic [7:0] x;
    int         w;
    int         n;

    reset          = 1'b1;
    adc_data       = 8'd0;
    comparator     = 1'b0;
    arm            = 1'b0;
    abort          = 1'b0;
    timeout_cycles = 16'd0;
    rd_en          = 1'b0;
    rd_addr        = 10'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_done",      32'(done),      32'(0));
    chk("rst_timed_out", 32'(timed_out), 32'(0));
    chk("rst_trig_pos",  32'(trig_pos),  32'(0));
    chk("rst_rd_valid",  32'(rd_valid),  32'(0));
    chk("rst_rd_data",   32'(rd_data),   32'(0));
    reset = 1'b0;
    tick();
    wp = 10'd0;

    // Capture 1: ramp, stray pulse during FILL, trigger on sample 0x90,
    // arm pulse during POST must be ignored.
    arm_capture();
    chk("t1_busy_fill", 32'(busy), 32'(1));
    for (int i = 0; i < PRE; i++) begin
      if (i == 10) comparator = 1'b1;
      if (i == 14) comparator = 1'b0;
      tick();
    end
    chk("t1_busy_wait", 32'(busy), 32'(1));
    chk("t1_done_wait", 32'(done), 32'(0));
    w = 0;
    while (adc_data != 8'h90 && w < 300) begin
      tick();
      w++;
    end
    chk("t1_sample_90", 32'(adc_data), 32'(8'h90));
    comparator = 1'b1;
    exp_trig = wp + 10'(67 + w);
    wait_done(2000, 100, n);
    chk("t1_post_cycles", 32'(n), 32'(963));
    chk("t1_trig_pos",    32'(trig_pos),  32'(exp_trig));
    chk("t1_busy_done",   32'(busy),      32'(0));
    chk("t1_timed_out",   32'(timed_out), 32'(0));
    rd("t1_ofs64",   10'd64,   1'b1, 1'b1, 8'h90);
    rd("t1_ofs63",   10'd63,   1'b1, 1'b1, 8'h8F);
    rd("t1_ofs0",    10'd0,    1'b1, 1'b1, 8'h50);
    rd("t1_ofs1023", 10'd1023, 1'b1, 1'b1, 8'h4F);
    for (int k = 0; k < 6; k++) begin
      off = 10'($urandom_range(0, 1023));
      rd("t1_rand", off, 1'b1, 1'b1, 8'h50 + off[7:0]);
    end
    wp = wp + 10'(1027 + w);

    // Capture 2: re-arm from DONE; edge and timeout land on the same cycle.
    timeout_cycles = 16'd4;
    arm_capture();
    chk("t2_rearm_done", 32'(done), 32'(0));
    chk("t2_rearm_busy", 32'(busy), 32'(1));
    repeat (PRE) tick();
    comparator = 1'b1;
    x = adc_data;
    exp_trig = wp + 10'd67;
    wait_done(2000, -1, n);
    chk("t2_post_cycles", 32'(n),         32'(963));
    chk("t2_timed_out",   32'(timed_out), 32'(0));
    chk("t2_trig_pos",    32'(trig_pos),  32'(exp_trig));
    rd("t2_ofs64", 10'd64, 1'b1, 1'b1, x);
    rd("t2_ofs0",  10'd0,  1'b1, 1'b1, x - 8'd64);
    wp = wp + 10'd1027;

    // Capture 3: timeout of 100 cycles without a comparator edge.
    timeout_cycles = 16'd100;
    arm_capture();
    repeat (PRE) tick();
    exp_trig = wp + 10'd163;
    wait_done(300, -1, n);
    chk("t3_wait_cycles", 32'(n),         32'(100));
    chk("t3_timed_out",   32'(timed_out), 32'(1));
    chk("t3_busy",        32'(busy),      32'(0));
    chk("t3_trig_pos",    32'(trig_pos),  32'(exp_trig));
    rd("t3_ofs10", 10'd10, 1'b1, 1'b0, 8'h00);

    // Capture 4: abort in mid-POST, then abort beating arm, then a clean capture.
    timeout_cycles = 16'd0;
    arm_capture();
    chk("t4_arm_clr_tmo", 32'(timed_out), 32'(0));
    repeat (PRE) tick();
    comparator = 1'b1;
    repeat (500) tick();
    comparator = 1'b0;
    chk("t4_busy_post", 32'(busy), 32'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_busy", 32'(busy), 32'(0));
    chk("t4_abort_done", 32'(done), 32'(0));
    rd("t4_rd_idle", 10'd5, 1'b0, 1'b0, 8'h00);
    abort = 1'b1;
    arm   = 1'b1;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    chk("t4_abort_vs_arm", 32'(busy), 32'(0));
    arm_capture();
    repeat (PRE) tick();
    comparator = 1'b1;
    x = adc_data;
    wait_done(2000, -1, n);
    chk("t4_post_cycles", 32'(n),         32'(963));
    chk("t4_timed_out",   32'(timed_out), 32'(0));
    rd("t4_ofs64",   10'd64,   1'b1, 1'b1, x);
    rd("t4_ofs0",    10'd0,    1'b1, 1'b1, x - 8'd64);
    rd("t4_ofs1023", 10'd1023, 1'b1, 1'b1, x + 8'hBF);

    // Asynchronous reset while waiting for a trigger.
    arm_capture();
    repeat (PRE + 5) tick();
    chk("t5_busy_pre", 32'(busy), 32'(1));
    #3;
    reset = 1'b1;
    #1;
    chk("t5_busy",      32'(busy),      32'(0));
    chk("t5_done",      32'(done),      32'(0));
    chk("t5_timed_out", 32'(timed_out), 32'(0));
    chk("t5_trig_pos",  32'(trig_pos),  32'(0));
    chk("t5_rd_valid",  32'(rd_valid),  32'(0));
    chk("t5_rd_data",   32'(rd_data),   32'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t5_idle_after", 32'(busy), 32'(0));

    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
